// File: rtl/load_store_ctrl_if.sv
// ---------------------------------------------------------------------------
// load_store_ctrl_if
//   Data-memory bus between the load/store controller (master) and the
//   data memory (slave).
//
//   Handshake: the master holds exactly one strobe (MemRead or MemWrite)
//   together with Address/WriteData stable until the slave raises mem_ready
//   for one cycle; the access completes on that rising edge. The two strobes
//   are never high together. data is meaningful only while MemRead and
//   mem_ready are both high.
//
//   Signals:
//     Address    master->slave  32  word-aligned byte address
//     WriteData  master->slave  32  full word to write
//     MemRead    master->slave  1   read strobe
//     MemWrite   master->slave  1   write strobe
//     data       slave->master  32  read data, little-endian
//     mem_ready  slave->master  1   current strobe completes this cycle
// ---------------------------------------------------------------------------
interface load_store_ctrl_if;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] data;
  logic        mem_ready;

  modport master (
    output Address, WriteData, MemRead, MemWrite,
    input  data, mem_ready
  );

  modport slave (
    input  Address, WriteData, MemRead, MemWrite,
    output data, mem_ready
  );
endinterface

// File: rtl/load_store_ctrl.sv
// ---------------------------------------------------------------------------
// load_store_ctrl
//   CPU-side initiator for the data memory. Takes one load/store from the
//   MEM stage, runs the memory access (read-modify-write for byte/half
//   stores, since memory only writes full words), extends load data and
//   stalls the pipeline until the access completes.
//
//   Optional feature macro: MISALIGN_TRAP_EN
//     defined   - misaligned half/word accesses are trapped (misalign_o
//                 pulse, no memory strobe)
//     undefined - low address bits below the access size are forced to 0
//                 and misalign_o is tied 0
//
//   Parameters:
//     TIMEOUT_CYC  max cycles waiting for mem_ready per phase (0 = never)
//     CNT_W        timeout counter width, 2**CNT_W > TIMEOUT_CYC
//
//   Ports:
//     clk_i, rst_i       clock, synchronous active-high reset
//     req_i              request (sampled in IDLE only)
//     memread_i          request is a load
//     memwrite_i         request is a store
//     size_i             00 byte, 01 half, 10 word, 11 illegal
//     unsigned_i         zero-extend loads when 1
//     addr_i, wdata_i    byte address, right-justified store data
//     stall_o            hold pipeline
//     rdata_o            extended load result (holds until next load)
//     rvalid_o           one-cycle pulse: load result valid
//     done_o             one-cycle pulse: access finished OK
//     err_o              one-cycle pulse: illegal request or timeout
//     misalign_o         one-cycle pulse: misaligned access trapped
//     dbg_state_o        current FSM state
//     mem                memory bus, master side
// ---------------------------------------------------------------------------
module load_store_ctrl #(
  parameter int TIMEOUT_CYC = 15,
  parameter int CNT_W       = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                memread_i,
  input  logic                memwrite_i,
  input  logic [1:0]          size_i,
  input  logic                unsigned_i,
  input  logic [31:0]         addr_i,
  input  logic [31:0]         wdata_i,
  output logic                stall_o,
  output logic [31:0]         rdata_o,
  output logic                rvalid_o,
  output logic                done_o,
  output logic                err_o,
  output logic                misalign_o,
  output logic [2:0]          dbg_state_o,
  load_store_ctrl_if.master   mem
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  // Last count value before a timeout; only meaningful when TIMEOUT_CYC != 0.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t            state_q;
  logic [31:0]       addr_q;
  logic [1:0]        off_q;
  logic [1:0]        size_q;
  logic              unsigned_q;
  logic              is_load_q;
  logic [31:0]       sdata_q;
  logic [31:0]       wd_q;
  logic [31:0]       rdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              rd_q;
  logic              wr_q;
  logic              done_q;
  logic              rvalid_q;
  logic              err_q;

  logic              bad_req;
  logic [1:0]        eff_off;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [31:0]       ld_val;
  logic [31:0]       merged;
  logic              timeout_hit;

`ifdef MISALIGN_TRAP_EN
  logic              misaligned;
  logic              mis_q;
`endif

  always_comb begin
    // Exactly one of load/store must be requested, and size 11 is illegal.
    bad_req = ~(memread_i ^ memwrite_i) | (size_i == 2'b11);

    // Lane offset with the bits below the access size cleared.
    case (size_i)
      2'b00:   eff_off = addr_i[1:0];
      2'b01:   eff_off = {addr_i[1], 1'b0};
      default: eff_off = 2'b00;
    endcase

    lane_b = mem.data[{off_q, 3'b000} +: 8];
    lane_h = off_q[1] ? mem.data[31:16] : mem.data[15:0];

    case (size_q)
      2'b00:   ld_val = unsigned_q ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   ld_val = unsigned_q ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: ld_val = mem.data;
    endcase

    // Read-modify-write: replace only the addressed lane of the fetched word.
    merged = mem.data;
    case (size_q)
      2'b00: merged[{off_q, 3'b000} +: 8] = sdata_q[7:0];
      2'b01: begin
        if (off_q[1]) merged[31:16] = sdata_q[15:0];
        else          merged[15:0]  = sdata_q[15:0];
      end
      default: merged = sdata_q;
    endcase

    timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == TO_LAST);

`ifdef MISALIGN_TRAP_EN
    misaligned = ((size_i == 2'b01) && addr_i[0]) ||
                 ((size_i == 2'b10) && (addr_i[1:0] != 2'b00));
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      off_q      <= '0;
      size_q     <= '0;
      unsigned_q <= 1'b0;
      is_load_q  <= 1'b0;
      sdata_q    <= '0;
      wd_q       <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      done_q     <= 1'b0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      mis_q      <= 1'b0;
`endif
    end else begin
      // Status outputs are single-cycle pulses.
      done_q   <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      mis_q    <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (req_i) begin
            if (bad_req) begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end
`ifdef MISALIGN_TRAP_EN
            else if (misaligned) begin
              state_q <= S_ERR;
              mis_q   <= 1'b1;
            end
`endif
            else begin
              addr_q     <= {addr_i[31:2], 2'b00};
              off_q      <= eff_off;
              size_q     <= size_i;
              unsigned_q <= unsigned_i;
              is_load_q  <= memread_i;
              sdata_q    <= wdata_i;
              cnt_q      <= '0;
              // Loads and sub-word stores both start with a read.
              if (memread_i || (size_i != 2'b10)) begin
                state_q <= S_RD;
                rd_q    <= 1'b1;
              end else begin
                state_q <= S_WR;
                wr_q    <= 1'b1;
                wd_q    <= wdata_i;
              end
            end
          end
        end

        S_RD: begin
          if (mem.mem_ready) begin
            rd_q  <= 1'b0;
            cnt_q <= '0;
            if (is_load_q) begin
              rdata_q  <= ld_val;
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              rvalid_q <= 1'b1;
            end else begin
              wd_q    <= merged;
              wr_q    <= 1'b1;
              state_q <= S_WR;
            end
          end else if (timeout_hit) begin
            rd_q    <= 1'b0;
            state_q <= S_ERR;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_WR: begin
          if (mem.mem_ready) begin
            wr_q    <= 1'b0;
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else if (timeout_hit) begin
            wr_q    <= 1'b0;
            state_q <= S_ERR;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_DONE:  state_q <= S_IDLE;
        S_ERR:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stall_o       = ((state_q == S_IDLE) && req_i) ||
                         (state_q == S_RD) || (state_q == S_WR);
  assign rdata_o       = rdata_q;
  assign rvalid_o      = rvalid_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign dbg_state_o   = state_q;
  assign mem.Address   = addr_q;
  assign mem.WriteData = wd_q;
  assign mem.MemRead   = rd_q;
  assign mem.MemWrite  = wr_q;

`ifdef MISALIGN_TRAP_EN
  assign misalign_o = mis_q;
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_ctrl.sv
module tb_load_store_ctrl;

  logic        clk;
  logic        rst_i;
  logic        req_i;
  logic        memread_i;
  logic        memwrite_i;
  logic [1:0]  size_i;
  logic        unsigned_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        rvalid_o;
  logic        done_o;
  logic        err_o;
  logic        misalign_o;
  logic [2:0]  dbg_state_o;
  logic        ready_en;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] mem_arr [0:15];

  load_store_ctrl_if mem_if ();

  load_store_ctrl #(
    .TIMEOUT_CYC (4),
    .CNT_W       (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .memread_i   (memread_i),
    .memwrite_i  (memwrite_i),
    .size_i      (size_i),
    .unsigned_i  (unsigned_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .stall_o     (stall_o),
    .rdata_o     (rdata_o),
    .rvalid_o    (rvalid_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .misalign_o  (misalign_o),
    .dbg_state_o (dbg_state_o),
    .mem         (mem_if.master)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // simple word memory
  assign mem_if.data      = mem_arr[mem_if.Address[5:2]];
  assign mem_if.mem_ready = ready_en;

  always @(posedge clk) begin
    if (mem_if.MemWrite && mem_if.mem_ready)
      mem_arr[mem_if.Address[5:2]] <= mem_if.WriteData;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request for a single cycle; returns at the negedge of the
  // cycle after acceptance (first access cycle).
  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    memread_i  = rd;
    memwrite_i = wr;
    size_i     = sz;
    unsigned_i = uns;
    addr_i     = a;
    wdata_i    = wd;
    req_i      = 1'b1;
    #1 chk("stall_in_accept", {31'd0, stall_o}, 32'd1);
    @(negedge clk);
    req_i = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem_arr[i] = 32'h0;
    mem_arr[4] = 32'h8899AABB;
    rst_i = 1'b1; req_i = 1'b0; memread_i = 1'b0; memwrite_i = 1'b0;
    size_i = 2'b00; unsigned_i = 1'b0; addr_i = '0; wdata_i = '0; ready_en = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_state", {29'd0, dbg_state_o}, 32'd0);
    chk("rst_outs", {26'd0, stall_o, rvalid_o, done_o, err_o, misalign_o,
                     mem_if.MemRead | mem_if.MemWrite}, 32'd0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_addr", mem_if.Address, 32'h0);
    rst_i = 1'b0;

    // lw 0x10
    issue(1, 0, 2'b10, 0, 32'h10, 0);
    chk("lw_memread", {31'd0, mem_if.MemRead}, 32'd1);
    chk("lw_memwrite", {31'd0, mem_if.MemWrite}, 32'd0);
    chk("lw_addr", mem_if.Address, 32'h10);
    chk("lw_stall_rd", {31'd0, stall_o}, 32'd1);
    @(negedge clk);
    chk("lw_rvalid", {31'd0, rvalid_o}, 32'd1);
    chk("lw_done", {31'd0, done_o}, 32'd1);
    chk("lw_rdata", rdata_o, 32'h8899AABB);
    chk("lw_stall_done", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    chk("lw_rvalid_pulse", {31'd0, rvalid_o}, 32'd0);
    chk("lw_rdata_hold", rdata_o, 32'h8899AABB);

    // lb / lbu 0x13, lhu 0x12, lh 0x10
    issue(1, 0, 2'b00, 0, 32'h13, 0);
    @(negedge clk);
    chk("lb_rdata", rdata_o, 32'hFFFFFF88);
    issue(1, 0, 2'b00, 1, 32'h13, 0);
    @(negedge clk);
    chk("lbu_rdata", rdata_o, 32'h00000088);
    issue(1, 0, 2'b01, 1, 32'h12, 0);
    @(negedge clk);
    chk("lhu_rdata", rdata_o, 32'h00008899);
    issue(1, 0, 2'b01, 0, 32'h10, 0);
    @(negedge clk);
    chk("lh_rdata", rdata_o, 32'hFFFFAABB);

    // sh 0x1234 at 0x12 (read-modify-write)
    issue(0, 1, 2'b01, 0, 32'h12, 32'h00001234);
    chk("sh_rd_phase", {30'd0, mem_if.MemRead, mem_if.MemWrite}, 32'b10);
    @(negedge clk);
    chk("sh_wr_phase", {30'd0, mem_if.MemRead, mem_if.MemWrite}, 32'b01);
    chk("sh_wdata", mem_if.WriteData, 32'h1234AABB);
    chk("sh_addr", mem_if.Address, 32'h10);
    @(negedge clk);
    chk("sh_done", {30'd0, done_o, rvalid_o}, 32'b10);
    chk("sh_stall", {31'd0, stall_o}, 32'd0);
    chk("sh_rdata_hold", rdata_o, 32'hFFFFAABB);
    chk("sh_mem", mem_arr[4], 32'h1234AABB);

    // sw 0xDEADBEEF at 0x20
    issue(0, 1, 2'b10, 0, 32'h20, 32'hDEADBEEF);
    chk("sw_wr_phase", {30'd0, mem_if.MemRead, mem_if.MemWrite}, 32'b01);
    chk("sw_wdata", mem_if.WriteData, 32'hDEADBEEF);
    chk("sw_addr", mem_if.Address, 32'h20);
    @(negedge clk);
    chk("sw_done", {31'd0, done_o}, 32'd1);
    chk("sw_mem", mem_arr[8], 32'hDEADBEEF);

    // illegal requests
    issue(1, 0, 2'b11, 0, 32'h10, 0);
    chk("ill_size_err", {29'd0, err_o, done_o, mem_if.MemRead}, 32'b100);
    chk("ill_size_stall", {31'd0, stall_o}, 32'd0);
    issue(1, 1, 2'b10, 0, 32'h10, 0);
    chk("ill_both_err", {28'd0, err_o, done_o, mem_if.MemRead, mem_if.MemWrite}, 32'b1000);
    issue(0, 0, 2'b10, 0, 32'h10, 0);
    chk("ill_none_err", {31'd0, err_o}, 32'd1);

    // timeout with ready held low (TIMEOUT_CYC = 4)
    ready_en = 1'b0;
    issue(1, 0, 2'b10, 0, 32'h10, 0);
    for (int i = 0; i < 4; i++) begin
      chk("to_memread_high", {31'd0, mem_if.MemRead}, 32'd1);
      @(negedge clk);
    end
    chk("to_err", {29'd0, err_o, done_o, mem_if.MemRead}, 32'b100);
    ready_en = 1'b1;
    @(negedge clk);
    chk("to_idle", {29'd0, dbg_state_o}, 32'd0);

    // lw 0x11
    issue(1, 0, 2'b10, 0, 32'h11, 0);
`ifdef MISALIGN_TRAP_EN
    chk("mis_pulse", {29'd0, misalign_o, err_o, mem_if.MemRead}, 32'b100);
    @(negedge clk);
    chk("mis_after", {30'd0, misalign_o, mem_if.MemRead}, 32'b00);
`else
    chk("mis_off_read", {30'd0, mem_if.MemRead, misalign_o}, 32'b10);
    chk("mis_off_addr", mem_if.Address, 32'h10);
    @(negedge clk);
    chk("mis_off_rdata", rdata_o, 32'h1234AABB);
`endif

    // reset during the read phase of sb
    ready_en = 1'b0;
    issue(0, 1, 2'b00, 0, 32'h10, 32'h000000CC);
    chk("rst_mid_rd", {31'd0, mem_if.MemRead}, 32'd1);
    rst_i = 1'b1;
    @(negedge clk);
    chk("rst_mid_outs", {26'd0, stall_o, rvalid_o, done_o, err_o,
                         mem_if.MemRead, mem_if.MemWrite}, 32'd0);
    chk("rst_mid_rdata", rdata_o, 32'h0);
    chk("rst_mid_addr", mem_if.Address, 32'h0);
    chk("rst_mid_state", {29'd0, dbg_state_o}, 32'd0);
    rst_i = 1'b0;
    ready_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid_no_write", {31'd0, mem_if.MemWrite}, 32'd0);
    end
    chk("rst_mid_mem", mem_arr[4], 32'h1234AABB);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
